// File: rtl/hazard_pkg.sv
// Shared optype and forward-select encodings for the ID-stage hazard logic.
// The decoder drives hazard_optype with the same OPT_* values.
package hazard_pkg;

    typedef enum logic [1:0] {
        OPT_NONE   = 2'b00,
        OPT_ALU    = 2'b01,
        OPT_LOAD   = 2'b10,
        OPT_BRANCH = 2'b11
    } opt_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_EXE_ALU = 2'b01,
        FWD_MEM_ALU = 2'b10,
        FWD_MEM_LD  = 2'b11
    } fwd_e;

    // Only ALU results and loads ever write a register.
    function automatic logic writes_rd(input opt_e op);
        return (op == OPT_ALU) || (op == OPT_LOAD);
    endfunction

endpackage

// File: rtl/hazard_detection_unit_fwd_sel.sv
// Priority forward-source select for one ID-stage operand.
// The youngest producer wins; a load still in EXE cannot forward.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic       i_match_exe,
    input  opt_e       i_op_exe,
    input  logic       i_match_mem,
    input  opt_e       i_op_mem,
    output logic [1:0] o_sel
);

    logic w_exe_alu;
    logic w_mem_alu;
    logic w_mem_ld;

    assign w_exe_alu = i_match_exe && (i_op_exe == OPT_ALU);
    assign w_mem_alu = i_match_mem && (i_op_mem == OPT_ALU);
    assign w_mem_ld  = i_match_mem && (i_op_mem == OPT_LOAD);

    always_comb begin
        o_sel = FWD_REG;
        priority case (1'b1)
            w_exe_alu: o_sel = FWD_EXE_ALU;
            w_mem_alu: o_sel = FWD_MEM_ALU;
            w_mem_ld:  o_sel = FWD_MEM_LD;
            default:   o_sel = FWD_REG;
        endcase
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall, branch flush and operand forwarding control beside ID.
// Tracks rd/optype of the EXE and MEM instructions in a shadow pipeline.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int NUM_FWD_SRC = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     hazard_optype_ID,
    input  logic                           rs1use_ID,
    input  logic                           rs2use_ID,
    input  logic                           mem_w_ID,
    input  logic [REG_AW-1:0]              rs1_ID,
    input  logic [REG_AW-1:0]              rs2_ID,
    input  logic [REG_AW-1:0]              rd_ID,
    input  logic                           Branch_ID,
    output logic                           PC_EN_IF,
    output logic                           reg_FD_EN,
    output logic                           reg_FD_flush,
    output logic                           reg_DE_flush,
    output logic [$clog2(NUM_FWD_SRC)-1:0] forward_ctrl_A,
    output logic [$clog2(NUM_FWD_SRC)-1:0] forward_ctrl_B,
    output logic                           forward_ctrl_ls
);

    logic [REG_AW-1:0] r_rd_exe;
    logic [REG_AW-1:0] r_rd_mem;
    opt_e              r_op_exe;
    opt_e              r_op_mem;
    logic              r_ls_exe;

    logic w_m1_exe;
    logic w_m2_exe;
    logic w_m1_mem;
    logic w_m2_mem;
    logic w_exe_ld;
    logic w_load_stall;
    logic w_store_fwd;
    opt_e w_op_id;

    assign w_m1_exe = rs1use_ID && (rs1_ID != '0) &&
                      (rs1_ID == r_rd_exe) && writes_rd(r_op_exe);
    assign w_m2_exe = rs2use_ID && (rs2_ID != '0) &&
                      (rs2_ID == r_rd_exe) && writes_rd(r_op_exe);
    assign w_m1_mem = rs1use_ID && (rs1_ID != '0) &&
                      (rs1_ID == r_rd_mem) && writes_rd(r_op_mem);
    assign w_m2_mem = rs2use_ID && (rs2_ID != '0) &&
                      (rs2_ID == r_rd_mem) && writes_rd(r_op_mem);

    // Store data from a load is bypassed in EXE, so it never stalls.
    assign w_exe_ld     = (r_op_exe == OPT_LOAD);
    assign w_load_stall = w_exe_ld && (w_m1_exe || (w_m2_exe && !mem_w_ID));
    assign w_store_fwd  = w_exe_ld && w_m2_exe && mem_w_ID && !w_load_stall;

    assign w_op_id = (opt_e'(hazard_optype_ID) == OPT_BRANCH) ?
                     OPT_NONE : opt_e'(hazard_optype_ID);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_exe <= '0;
            r_op_exe <= OPT_NONE;
            r_rd_mem <= '0;
            r_op_mem <= OPT_NONE;
            r_ls_exe <= 1'b0;
        end else begin
            r_rd_mem <= r_rd_exe;
            r_op_mem <= r_op_exe;
            if (w_load_stall) begin
                r_rd_exe <= '0;
                r_op_exe <= OPT_NONE;
                r_ls_exe <= 1'b0;
            end else begin
                r_rd_exe <= rd_ID;
                r_op_exe <= w_op_id;
                r_ls_exe <= w_store_fwd;
            end
        end
    end

    fwd_sel u_fwd_a (
        .i_match_exe (w_m1_exe),
        .i_op_exe    (r_op_exe),
        .i_match_mem (w_m1_mem),
        .i_op_mem    (r_op_mem),
        .o_sel       (forward_ctrl_A)
    );

    fwd_sel u_fwd_b (
        .i_match_exe (w_m2_exe),
        .i_op_exe    (r_op_exe),
        .i_match_mem (w_m2_mem),
        .i_op_mem    (r_op_mem),
        .o_sel       (forward_ctrl_B)
    );

    assign PC_EN_IF        = !w_load_stall;
    assign reg_FD_EN       = !w_load_stall;
    assign reg_DE_flush    = w_load_stall;
    assign reg_FD_flush    = Branch_ID && !w_load_stall;
    assign forward_ctrl_ls = r_ls_exe;

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Sits beside the ID stage of the 5-stage RV32I pipeline and consumes the decoder's hazard_optype, rs1use, rs2use and mem_w, plus the ID-stage register indices.
- Keeps its own shadow pipeline of destination register and optype for EXE and MEM.
- Produces three groups of outputs: operand-forwarding selects for the ID-stage operand muxes, load-use stall controls, and branch/jump flushes.

Parameters:
- REG_AW, 5, register-index width.
- NUM_FWD_SRC, 4, number of forward-mux inputs; fixed, it fixes the 2-bit encoding.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- hazard_optype_ID  in  2  from decoder: 00 none, 01 ALU writes rd, 10 load, 11 branch/no rd
- rs1use_ID  in  1  ID instruction reads rs1
- rs2use_ID  in  1  ID instruction reads rs2
- mem_w_ID  in  1  ID instruction is a store
- rs1_ID  in  REG_AW  inst[19:15]
- rs2_ID  in  REG_AW  inst[24:20]
- rd_ID  in  REG_AW  inst[11:7]
- Branch_ID  in  1  taken branch or JAL/JALR redirect resolved in ID
- PC_EN_IF  out  1  PC write enable
- reg_FD_EN  out  1  IF/ID register enable
- reg_FD_flush  out  1  IF/ID flush
- reg_DE_flush  out  1  ID/EX flush (bubble insert)
- forward_ctrl_A  out  2  rs1 source: 00 regfile, 01 EXE ALU out, 10 MEM ALU out, 11 MEM load data
- forward_ctrl_B  out  2  rs2 source, same encoding
- forward_ctrl_ls  out  1  registered; store in EXE takes its data from the MEM load data

Behaviour:
- Shadow registers: rd_EXE, op_EXE, rd_MEM, op_MEM, ls_EXE.
  - Reset (rst_n low at a clk edge) clears all to 0.
  - Reset mid-stall releases the stall on the next cycle.
- Shadow register update, every edge:
  - MEM <= EXE.
  - EXE <= {rd_ID, hazard_optype_ID} unless load_stall, in which case EXE <= {0, 00} (bubble).
  - optype 11 is stored as 00 (no rd).
- Match rules:
  - match1_X = rs1use_ID & rs1_ID != 0 & rs1_ID == rd_X & op_X in {01,10}.
  - match2_X is the same for rs2.
  - rd or rs == x0 never matches.
- load_stall, combinational:
  - Asserted when op_EXE == 10 and match1_EXE, or match2_EXE & !mem_w_ID.
  - Store-data dependence on a load does not stall.
- store_fwd = op_EXE == 10 & match2_EXE & mem_w_ID & !load_stall.
  - Registered into ls_EXE; forward_ctrl_ls = ls_EXE.
  - Bubble or reset clears it.
- forward_ctrl_A priority, youngest first:
  - 01 if match1_EXE & op_EXE == 01.
  - else 10 if match1_MEM & op_MEM == 01.
  - else 11 if match1_MEM & op_MEM == 10.
  - else 00.
  - forward_ctrl_B uses the same rules with match2.
  - During load_stall the value is don't-care, but driven per the same rules.
- Stall outputs: PC_EN_IF = !load_stall; reg_FD_EN = !load_stall; reg_DE_flush = load_stall.
- Flush: reg_FD_flush = Branch_ID & !load_stall.
  - A branch stalled on a load is not taken that cycle; it re-resolves after the bubble.
- Reset outputs: PC_EN_IF = 1, reg_FD_EN = 1, both flushes 0, all forward selects 0.
  - Outputs are combinational from inputs plus shadow state, so these values follow from cleared state with idle inputs.
- Latency:
  - Stall is exactly one cycle per load-use.
  - Back-to-back dependent loads stall once each.
- Simultaneous conditions:
  - Stall has priority over flush.
  - An EXE match beats a MEM match on the same register.

Decomposition:
- Shared package hazard_pkg:
  - OPT_NONE/OPT_ALU/OPT_LOAD/OPT_BRANCH (2-bit).
  - FWD_REG/FWD_EXE_ALU/FWD_MEM_ALU/FWD_MEM_LD (2-bit).
  - The decoder must use the same OPT_* constants.
- One sub-module, fwd_sel: pure combinational priority select for one operand, instantiated twice (A, B).

Test Plan:
- add x5 (op 01, rd 5) then ID reads rs1 = 5 -> forward_ctrl_A = 01, no stall. One cycle later, with a non-writing instruction in between -> forward_ctrl_A = 10.
- lw x6 then add rs2 = x6 -> cycle 1: PC_EN_IF = 0, reg_FD_EN = 0, reg_DE_flush = 1. Cycle 2: forward_ctrl_B = 11, no stall.
- lw x7 then sw rs2 = x7, rs1 = x2 -> no stall; next cycle forward_ctrl_ls = 1, then 0 the following cycle.
- lw x8 then beq rs1 = x8 with Branch_ID = 1 -> cycle 1: stall and reg_FD_flush = 0. Cycle 2: forward_ctrl_A = 11, reg_FD_flush = 1.
- addi x0 then ID reads rs1 = 0 -> forward_ctrl_A = 00. Also: addi x9 in EXE and lw x9 in MEM -> EXE wins, forward 01.
- rst_n low during a load_stall cycle -> next cycle PC_EN_IF = 1, all shadow ops 00, forward_ctrl_ls = 0.
